// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter
// Two-requester arbiter/sequencer in front of the pipelined AHB master.
// Commands from R0/R1 are serialised into the master's command port with a
// one-cycle AHB_START strobe. A small tag FIFO records who issued each read so
// returned data is steered back to the right requester.
//
// Build option: define AHB_ARB_FIXED_PRIO_EN for fixed priority (R0 always wins
// a contest); otherwise arbitration is round-robin.
//
// Handshake: a command transfers on the rising edge where R*_VALID and R*_READY
// are both 1. READY is only raised in IDLE and only for one cycle. The
// requester must hold its payload stable while VALID is 1 and READY is 0.
// RVALID has no backpressure; it is a one-cycle pulse and RDATA holds the
// value until the next delivery to the same port.
module ahb_master_arbiter #(
  parameter int C_M_AHB_ADDR_WIDTH = 32,
  parameter int C_M_AHB_DATA_WIDTH = 32,
  parameter int C_TAG_DEPTH        = 8,
  parameter int C_TAG_ADDR_WIDTH   = 3
) (
  input  logic                          M_HCLK,
  input  logic                          M_nREST,
  // requester 0
  input  logic                          R0_VALID,
  output logic                          R0_READY,
  input  logic [C_M_AHB_ADDR_WIDTH-1:0] R0_ADDR,
  input  logic [C_M_AHB_DATA_WIDTH-1:0] R0_WDATA,
  input  logic                          R0_WRITE,
  input  logic [2:0]                    R0_BURST,
  output logic                          R0_RVALID,
  output logic [C_M_AHB_DATA_WIDTH-1:0] R0_RDATA,
  // requester 1
  input  logic                          R1_VALID,
  output logic                          R1_READY,
  input  logic [C_M_AHB_ADDR_WIDTH-1:0] R1_ADDR,
  input  logic [C_M_AHB_DATA_WIDTH-1:0] R1_WDATA,
  input  logic                          R1_WRITE,
  input  logic [2:0]                    R1_BURST,
  output logic                          R1_RVALID,
  output logic [C_M_AHB_DATA_WIDTH-1:0] R1_RDATA,
  // master command interface
  output logic [C_M_AHB_ADDR_WIDTH-1:0] AR_SEND,
  output logic [C_M_AHB_DATA_WIDTH-1:0] DATA_SEND,
  output logic                          TRAN_TYPE,
  output logic [1:0]                    TRAN_STATUS,
  output logic [2:0]                    BURST_TYPE,
  output logic                          AHB_START,
  input  logic                          FIFO_FULL,
  // master receive interface
  input  logic                          RECV_FIFO_EMPTY,
  output logic                          RECV_RD,
  input  logic [C_M_AHB_DATA_WIDTH-1:0] DATA_RECV,
  // status
  output logic [C_TAG_ADDR_WIDTH:0]     OUTSTANDING,
  output logic                          ARB_ERR,
  // FSM state visibility
  output logic [1:0]                    dbg_issue_state,
  output logic [1:0]                    dbg_ret_state
);

  // Issue FSM encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  // Return FSM encoding
  localparam logic [1:0] R_IDLE    = 2'd0;
  localparam logic [1:0] R_STROBE  = 2'd1;
  localparam logic [1:0] R_WAIT    = 2'd2;
  localparam logic [1:0] R_DELIVER = 2'd3;

  localparam logic [1:0] NONSEQ = 2'b10;

  localparam logic [C_TAG_ADDR_WIDTH-1:0] PTR_LAST = C_TAG_ADDR_WIDTH'(C_TAG_DEPTH - 1);
  localparam logic [C_TAG_ADDR_WIDTH-1:0] PTR_ONE  = C_TAG_ADDR_WIDTH'(1);
  localparam logic [C_TAG_ADDR_WIDTH:0]   CNT_FULL = (C_TAG_ADDR_WIDTH + 1)'(C_TAG_DEPTH);
  localparam logic [C_TAG_ADDR_WIDTH:0]   CNT_ONE  = (C_TAG_ADDR_WIDTH + 1)'(1);

  logic [1:0] issue_state;
  logic [1:0] ret_state;
  logic       issue_owner;   // requester id of the command in flight

  logic       elig0;
  logic       elig1;
  logic       grant0;
  logic       grant1;

  // tag FIFO
  logic                        tag_mem [C_TAG_DEPTH];
  logic [C_TAG_ADDR_WIDTH-1:0] tag_wr_ptr;
  logic [C_TAG_ADDR_WIDTH-1:0] tag_rd_ptr;
  logic [C_TAG_ADDR_WIDTH:0]   tag_cnt;
  logic                        tag_full;
  logic                        tag_empty;
  logic                        tag_push;
  logic                        tag_pop;
  logic                        tag_head;

  assign tag_full  = (tag_cnt == CNT_FULL);
  assign tag_empty = (tag_cnt == '0);
  assign tag_head  = tag_mem[tag_rd_ptr];

  // Writes never wait on tag space; reads need a free tag slot.
  assign elig0 = R0_VALID && !FIFO_FULL && (R0_WRITE || !tag_full);
  assign elig1 = R1_VALID && !FIFO_FULL && (R1_WRITE || !tag_full);

`ifndef AHB_ARB_FIXED_PRIO_EN
  logic last_winner;  // 1 = R1 won the most recent grant

  // Remember who won last so a contest goes to the other requester.
  always_ff @(posedge M_HCLK or negedge M_nREST) begin
    if (!M_nREST) begin
      last_winner <= 1'b1;
    end else if (grant0) begin
      last_winner <= 1'b0;
    end else if (grant1) begin
      last_winner <= 1'b1;
    end
  end
`endif

  // Pick at most one winner, and only while the issue FSM is idle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (issue_state == IDLE) begin
`ifdef AHB_ARB_FIXED_PRIO_EN
      if (elig0) begin
        grant0 = 1'b1;
      end else if (elig1) begin
        grant1 = 1'b1;
      end
`else
      if (elig0 && elig1) begin
        grant0 = last_winner;
        grant1 = !last_winner;
      end else if (elig0) begin
        grant0 = 1'b1;
      end else if (elig1) begin
        grant1 = 1'b1;
      end
`endif
    end
  end

  assign R0_READY = grant0;
  assign R1_READY = grant1;

  // Issue FSM: register the winner's payload, then IDLE->SETUP->STROBE->HOLD.
  always_ff @(posedge M_HCLK or negedge M_nREST) begin
    if (!M_nREST) begin
      issue_state <= IDLE;
      issue_owner <= 1'b0;
      AR_SEND     <= '0;
      DATA_SEND   <= '0;
      TRAN_TYPE   <= 1'b0;
      BURST_TYPE  <= 3'b000;
    end else begin
      case (issue_state)
        IDLE: begin
          if (grant0 || grant1) begin
            issue_owner <= grant1;
            AR_SEND     <= grant1 ? R1_ADDR  : R0_ADDR;
            DATA_SEND   <= grant1 ? R1_WDATA : R0_WDATA;
            TRAN_TYPE   <= grant1 ? R1_WRITE : R0_WRITE;
            BURST_TYPE  <= grant1 ? R1_BURST : R0_BURST;
            issue_state <= SETUP;
          end
        end
        SETUP:   issue_state <= STROBE;
        STROBE:  issue_state <= HOLD;
        default: issue_state <= IDLE;
      endcase
    end
  end

  // Strobe straight from the state flops so reset drops it at once.
  assign AHB_START   = (issue_state == STROBE);
  assign TRAN_STATUS = NONSEQ;

  assign tag_push = (issue_state == STROBE) && !TRAN_TYPE;
  assign tag_pop  = (ret_state == R_DELIVER);

  // Tag storage needs no reset: only entries below the count are ever read.
  always_ff @(posedge M_HCLK) begin
    if (tag_push) begin
      tag_mem[tag_wr_ptr] <= issue_owner;
    end
  end

  // Tag pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge M_HCLK or negedge M_nREST) begin
    if (!M_nREST) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
    end else begin
      if (tag_push) begin
        tag_wr_ptr <= (tag_wr_ptr == PTR_LAST) ? '0 : tag_wr_ptr + PTR_ONE;
      end
      if (tag_pop) begin
        tag_rd_ptr <= (tag_rd_ptr == PTR_LAST) ? '0 : tag_rd_ptr + PTR_ONE;
      end
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + CNT_ONE;
        2'b01:   tag_cnt <= tag_cnt - CNT_ONE;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  assign OUTSTANDING = tag_cnt;

  // Return FSM: strobe the receive FIFO, wait a cycle for its data, then
  // deliver to the owner at the head of the tag FIFO.
  always_ff @(posedge M_HCLK or negedge M_nREST) begin
    if (!M_nREST) begin
      ret_state <= R_IDLE;
      R0_RVALID <= 1'b0;
      R1_RVALID <= 1'b0;
      R0_RDATA  <= '0;
      R1_RDATA  <= '0;
    end else begin
      R0_RVALID <= 1'b0;
      R1_RVALID <= 1'b0;
      case (ret_state)
        R_IDLE: begin
          if (!RECV_FIFO_EMPTY && !tag_empty) begin
            ret_state <= R_STROBE;
          end
        end
        R_STROBE: ret_state <= R_WAIT;
        R_WAIT: begin
          // Data read by the strobe is valid now; present it in R_DELIVER.
          if (tag_head) begin
            R1_RDATA  <= DATA_RECV;
            R1_RVALID <= 1'b1;
          end else begin
            R0_RDATA  <= DATA_RECV;
            R0_RVALID <= 1'b1;
          end
          ret_state <= R_DELIVER;
        end
        default: ret_state <= R_IDLE;
      endcase
    end
  end

  assign RECV_RD = (ret_state == R_STROBE);

  // Sticky error: the master holds read data nobody asked for.
  always_ff @(posedge M_HCLK or negedge M_nREST) begin
    if (!M_nREST) begin
      ARB_ERR <= 1'b0;
    end else if (!RECV_FIFO_EMPTY && tag_empty) begin
      ARB_ERR <= 1'b1;
    end
  end

  assign dbg_issue_state = issue_state;
  assign dbg_ret_state   = ret_state;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter with a small registered-read model of
// the master's receive FIFO.
module tb_ahb_master_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT signals ----------------
  logic        r0_valid, r1_valid;
  logic        r0_ready, r1_ready;
  logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
  logic        r0_write, r1_write;
  logic [2:0]  r0_burst, r1_burst;
  logic        r0_rvalid, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] ar_send, data_send;
  logic        tran_type;
  logic [1:0]  tran_status;
  logic [2:0]  burst_type;
  logic        ahb_start;
  logic        fifo_full;
  logic        recv_empty;
  logic        recv_rd;
  logic [31:0] data_recv = '0;
  logic [3:0]  outstanding;
  logic        arb_err;
  logic [1:0]  dbg_issue_state, dbg_ret_state;

  ahb_master_arbiter dut (
    .M_HCLK(clk), .M_nREST(rst_n),
    .R0_VALID(r0_valid), .R0_READY(r0_ready), .R0_ADDR(r0_addr), .R0_WDATA(r0_wdata),
    .R0_WRITE(r0_write), .R0_BURST(r0_burst), .R0_RVALID(r0_rvalid), .R0_RDATA(r0_rdata),
    .R1_VALID(r1_valid), .R1_READY(r1_ready), .R1_ADDR(r1_addr), .R1_WDATA(r1_wdata),
    .R1_WRITE(r1_write), .R1_BURST(r1_burst), .R1_RVALID(r1_rvalid), .R1_RDATA(r1_rdata),
    .AR_SEND(ar_send), .DATA_SEND(data_send), .TRAN_TYPE(tran_type),
    .TRAN_STATUS(tran_status), .BURST_TYPE(burst_type), .AHB_START(ahb_start),
    .FIFO_FULL(fifo_full), .RECV_FIFO_EMPTY(recv_empty), .RECV_RD(recv_rd),
    .DATA_RECV(data_recv), .OUTSTANDING(outstanding), .ARB_ERR(arb_err),
    .dbg_issue_state(dbg_issue_state), .dbg_ret_state(dbg_ret_state)
  );

  // ---------------- master receive FIFO model ----------------
  // Entries rd_idx..avail-1 are pending; a read strobe presents the head on
  // DATA_RECV one cycle later.
  logic [31:0] rd_tab [0:63];
  logic [5:0]  rd_idx = '0;
  logic [5:0]  avail  = '0;
  assign recv_empty = (rd_idx == avail);

  always @(posedge clk) begin
    if (recv_rd && (rd_idx != avail)) begin
      data_recv <= rd_tab[rd_idx];
      rd_idx    <= rd_idx + 6'd1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int req, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic w, input logic [2:0] b);
    if (req == 0) begin
      r0_valid = v; r0_addr = a; r0_wdata = d; r0_write = w; r0_burst = b;
    end else begin
      r1_valid = v; r1_addr = a; r1_wdata = d; r1_write = w; r1_burst = b;
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return r0_ready;
      1:       return r1_ready;
      2:       return r0_rvalid;
      3:       return r1_rvalid;
      default: return recv_rd;
    endcase
  endfunction

  // Wait (bounded) until the selected signal is high; returns mid-cycle.
  task automatic wait_hi(input int sel, input int budget, input string tag);
    bit ok = 0;
    for (int n = 0; n < budget; n++) begin
      #1;
      if (sig(sel)) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  // Raise VALID, wait for the grant, drop VALID. Returns in cycle N+1.
  task automatic send(input int req, input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic [2:0] b);
    set_req(req, 1'b1, a, d, w, b);
    wait_hi(req, 12, "send_ready");
    @(negedge clk);
    if (req == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int winner, last_cyc, starts;
    set_req(0, 1'b0, '0, '0, 1'b0, 3'b000);
    set_req(1, 1'b0, '0, '0, 1'b0, 3'b000);
    fifo_full = 1'b0;
    rst_n = 1'b0;
    tick(2);

    // reset values
    check("rst_r0_ready", 64'(r0_ready), 64'd0);
    check("rst_r1_ready", 64'(r1_ready), 64'd0);
    check("rst_rvalid", 64'({r0_rvalid, r1_rvalid}), 64'd0);
    check("rst_ahb_start", 64'(ahb_start), 64'd0);
    check("rst_recv_rd", 64'(recv_rd), 64'd0);
    check("rst_arb_err", 64'(arb_err), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_rdata", 64'({r0_rdata, r1_rdata}), 64'd0);
    check("rst_ar_send", 64'(ar_send), 64'd0);
    check("rst_data_send", 64'(data_send), 64'd0);
    check("rst_type_burst", 64'({tran_type, burst_type}), 64'd0);
    check("rst_tran_status", 64'(tran_status), 64'd2);
    check("rst_fsm_states", 64'({dbg_issue_state, dbg_ret_state}), 64'd0);
    rst_n = 1'b1;
    tick(1);

    // single R0 write: READY in N, AHB_START only in N+2
    set_req(0, 1'b1, 32'h100, 32'hA5A5A5A5, 1'b1, 3'b000);
    #1;
    check("wr_ready_n", 64'(r0_ready), 64'd1);
    check("wr_start_n", 64'(ahb_start), 64'd0);
    @(negedge clk);
    r0_valid = 1'b0;
    check("wr_start_n1", 64'(ahb_start), 64'd0);
    check("wr_addr_n1", 64'(ar_send), 64'h100);
    check("wr_ready_n1", 64'(r0_ready), 64'd0);
    tick(1);
    check("wr_start_n2", 64'(ahb_start), 64'd1);
    check("wr_addr_n2", 64'(ar_send), 64'h100);
    check("wr_data_n2", 64'(data_send), 64'hA5A5A5A5);
    check("wr_type_n2", 64'(tran_type), 64'd1);
    check("wr_status_n2", 64'(tran_status), 64'd2);
    check("wr_burst_n2", 64'(burst_type), 64'd0);
    tick(1);
    check("wr_start_n3", 64'(ahb_start), 64'd0);
    check("wr_data_n3", 64'(data_send), 64'hA5A5A5A5);
    tick(1);
    check("wr_start_n4", 64'(ahb_start), 64'd0);
    check("wr_no_tag", 64'(outstanding), 64'd0);

    // FIFO_FULL blocks acceptance while in IDLE
    fifo_full = 1'b1;
    set_req(0, 1'b1, 32'h104, 32'h1, 1'b1, 3'b000);
    #1;
    check("ff_block_a", 64'(r0_ready), 64'd0);
    tick(2);
    #1;
    check("ff_block_b", 64'(r0_ready), 64'd0);
    fifo_full = 1'b0;
    #1;
    check("ff_release", 64'(r0_ready), 64'd1);
    @(negedge clk);
    r0_valid = 1'b0;
    tick(3);

    // contested arbitration
    do_reset();
    set_req(0, 1'b1, 32'h400, 32'h44, 1'b1, 3'b001);
    set_req(1, 1'b1, 32'h500, 32'h55, 1'b1, 3'b011);
    last_cyc = 0;
    for (int g = 0; g < 4; g++) begin
      winner = 2;
      for (int n = 0; n < 8; n++) begin
        #1;
        if (r0_ready || r1_ready) begin
          winner = r1_ready ? 1 : 0;
          break;
        end
        @(negedge clk);
      end
`ifdef AHB_ARB_FIXED_PRIO_EN
      check("arb_winner", 64'(winner), 64'd0);
`else
      check("arb_winner", 64'(winner), 64'(g % 2));
`endif
      check("arb_one_grant", 64'(r0_ready && r1_ready), 64'd0);
      if (g > 0) check("arb_gap", 64'(cyc - last_cyc), 64'd4);
      last_cyc = cyc;
      @(negedge clk);
      check("arb_addr", 64'(ar_send), (winner == 1) ? 64'h500 : 64'h400);
      check("arb_burst", 64'(burst_type), (winner == 1) ? 64'd3 : 64'd1);
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    tick(3);

    // two reads, data steered to owners in issue order
    do_reset();
    send(0, 32'h200, 32'h0, 1'b0, 3'b000);
    check("rd_out_n1", 64'(outstanding), 64'd0);
    tick(1);
    check("rd_start", 64'(ahb_start), 64'd1);
    check("rd_type", 64'(tran_type), 64'd0);
    tick(1);
    check("rd_out_1", 64'(outstanding), 64'd1);
    tick(1);
    send(1, 32'h300, 32'h0, 1'b0, 3'b000);
    tick(2);
    check("rd_out_2", 64'(outstanding), 64'd2);
    tick(1);
    rd_tab[avail] = 32'h11111111; avail = avail + 6'd1;
    rd_tab[avail] = 32'h22222222; avail = avail + 6'd1;
    wait_hi(4, 8, "ret_recv_rd");
    tick(1);
    check("ret_wait_rd_low", 64'(recv_rd), 64'd0);
    check("ret_wait_no_rvalid", 64'(r0_rvalid), 64'd0);
    tick(1);
    check("ret_r0_rvalid", 64'(r0_rvalid), 64'd1);
    check("ret_r1_quiet", 64'(r1_rvalid), 64'd0);
    check("ret_r0_rdata", 64'(r0_rdata), 64'h11111111);
    check("ret_out_still_2", 64'(outstanding), 64'd2);
    tick(1);
    check("ret_out_1", 64'(outstanding), 64'd1);
    check("ret_r0_pulse", 64'(r0_rvalid), 64'd0);
    wait_hi(3, 10, "ret_r1_rvalid");
    check("ret_r1_rdata", 64'(r1_rdata), 64'h22222222);
    check("ret_r0_held", 64'(r0_rdata), 64'h11111111);
    tick(1);
    check("ret_out_0", 64'(outstanding), 64'd0);
    check("ret_no_err", 64'(arb_err), 64'd0);

    // tag FIFO full: R0 reads stall, R1 write still accepted
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(0, 32'h600 + 32'(i * 4), 32'h0, 1'b0, 3'b000);
      tick(3);
    end
    check("full_out_8", 64'(outstanding), 64'd8);
    set_req(0, 1'b1, 32'h700, 32'h0, 1'b0, 3'b000);
    set_req(1, 1'b1, 32'h800, 32'hBEEF, 1'b1, 3'b010);
    #1;
    check("full_r0_stall", 64'(r0_ready), 64'd0);
    check("full_r1_write", 64'(r1_ready), 64'd1);
    @(negedge clk);
    r1_valid = 1'b0;
    tick(1);
    check("full_wr_addr", 64'(ar_send), 64'h800);
    check("full_wr_start", 64'(ahb_start), 64'd1);
    tick(2);
    #1;
    check("full_r0_still", 64'(r0_ready), 64'd0);
    check("full_out_kept", 64'(outstanding), 64'd8);
    r0_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_tab[avail] = 32'hD000_0000 + 32'(i);
      exp_q.push_back(32'hD000_0000 + 32'(i));
      avail = avail + 6'd1;
    end
    for (int i = 0; i < 8; i++) begin
      wait_hi(2, 12, "drain_rvalid");
      check("drain_rdata", 64'(r0_rdata), 64'(exp_q.pop_front()));
      tick(1);
    end
    check("drain_out_0", 64'(outstanding), 64'd0);
    check("drain_no_err", 64'(arb_err), 64'd0);

    // receive data with no tag: no drain, sticky error
    do_reset();
    rd_tab[avail] = 32'hBAD0BAD0;
    avail = avail + 6'd1;
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (recv_rd) starts++;
    end
    check("err_no_drain", 64'(starts), 64'd0);
    check("err_set", 64'(arb_err), 64'd1);
    avail = rd_idx;
    tick(2);
    check("err_sticky", 64'(arb_err), 64'd1);
    rst_n = 1'b0;
    #1;
    check("err_cleared", 64'(arb_err), 64'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // reset while the issue FSM is in SETUP
    send(0, 32'h900, 32'h0, 1'b0, 3'b000);
    tick(3);
    check("mid_out_1", 64'(outstanding), 64'd1);
    send(0, 32'h904, 32'h55, 1'b1, 3'b000);
    check("mid_in_setup", 64'(dbg_issue_state), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_start", 64'(ahb_start), 64'd0);
    check("mid_out_0", 64'(outstanding), 64'd0);
    check("mid_payload", 64'({ar_send, data_send}), 64'd0);
    check("mid_type", 64'(tran_type), 64'd0);
    check("mid_states", 64'({dbg_issue_state, dbg_ret_state}), 64'd0);
    tick(1);
    rst_n = 1'b1;
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (ahb_start) starts++;
    end
    check("mid_no_start", 64'(starts), 64'd0);
    check("mid_out_end", 64'(outstanding), 64'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Two-requester arbiter and sequencer in front of the pipelined AHB master. It accepts write/read commands from two independent requesters and serialises them into the master's command interface. It generates the one-cycle AHB_START strobe with a stable payload. It tracks read ownership in a tag FIFO so returned read data is steered back to the requester that issued the read.

## Interface
- C_M_AHB_ADDR_WIDTH, 32, address width
- C_M_AHB_DATA_WIDTH, 32, data width
- C_TAG_DEPTH, 8, max outstanding reads; must equal the master's FIFO depth
- C_TAG_ADDR_WIDTH, 3, log2(C_TAG_DEPTH)

Ports:
- M_HCLK  in  1  system clock
- M_nREST  in  1  reset, asynchronous, active-low
- R0_VALID / R1_VALID  in  1  command request
- R0_READY / R1_READY  out  1  command accepted (one-cycle pulse)
- R0_ADDR / R1_ADDR  in  C_M_AHB_ADDR_WIDTH  transfer address
- R0_WDATA / R1_WDATA  in  C_M_AHB_DATA_WIDTH  write data
- R0_WRITE / R1_WRITE  in  1  1 = write, 0 = read
- R0_BURST / R1_BURST  in  3  HBURST code
- R0_RVALID / R1_RVALID  out  1  read data valid (one-cycle pulse, no backpressure)
- R0_RDATA / R1_RDATA  out  C_M_AHB_DATA_WIDTH  read data, held until the next delivery to that port
- AR_SEND  out  C_M_AHB_ADDR_WIDTH  command address to master
- DATA_SEND  out  C_M_AHB_DATA_WIDTH  command write data to master
- TRAN_TYPE  out  1  R*_WRITE of the granted requester
- TRAN_STATUS  out  2  constant 2'b10 (NONSEQ)
- BURST_TYPE  out  3  R*_BURST of the granted requester
- AHB_START  out  1  master command write strobe
- FIFO_FULL  in  1  master command FIFOs full
- RECV_FIFO_EMPTY  in  1  master receive FIFO empty
- RECV_RD  out  1  master receive FIFO read strobe
- DATA_RECV  in  C_M_AHB_DATA_WIDTH  master receive data
- OUTSTANDING  out  C_TAG_ADDR_WIDTH+1  reads issued but not yet delivered
- ARB_ERR  out  1  sticky flag: receive data present with no tag

## Operation
- The issue FSM has four states: IDLE, SETUP, STROBE and HOLD.
  - IDLE: a requester is eligible when its VALID is 1, FIFO_FULL is 0, and, for reads, the tag FIFO is not full.
  - Choose a winner among the eligible requesters, pulse its READY, register its payload into AR_SEND, DATA_SEND, TRAN_TYPE and BURST_TYPE, then go to SETUP.
  - SETUP -> STROBE: AHB_START = 1 for exactly one cycle.
  - STROBE -> HOLD: the payload is still stable.
  - HOLD -> IDLE.
- For a read, push the owner id into the tag FIFO in the STROBE cycle.
- Arbitration is round-robin:
  - when both requesters are eligible, grant the one that did not win last;
  - the last-winner flop resets to 1, so R0 wins the first contest.
- A write never waits on the tag FIFO. With the tag FIFO full, R1 writes are still accepted while R0 reads stall.
- The return FSM has four states: R_IDLE, R_STROBE, R_WAIT and R_DELIVER.
  - R_IDLE -> R_STROBE when RECV_FIFO_EMPTY = 0 and the tag FIFO is not empty.
  - R_STROBE: RECV_RD = 1.
  - R_WAIT: RECV_RD = 0.
  - R_DELIVER: capture DATA_RECV into the owner's RDATA, pulse the owner's RVALID, pop the tag, return to R_IDLE.
- If RECV_FIFO_EMPTY = 0 while the tag FIFO is empty, do not drain; set ARB_ERR, which stays set until reset.
- The issue and return FSMs run independently.
- OUTSTANDING = tag count. A push and a pop in the same cycle leave it unchanged.

## Timing
- Reset values (all outputs 0 or idle):
  - READY, RVALID, AHB_START, RECV_RD, ARB_ERR = 0; OUTSTANDING = 0.
  - RDATA, AR_SEND, DATA_SEND = 0; TRAN_TYPE = 0, BURST_TYPE = 0.
  - TRAN_STATUS = 2'b10; both FSMs idle.
- Reset mid-operation clears both FSMs and the tag FIFO immediately. Strobes drop asynchronously and outstanding tags are discarded.
- Command throughput: one command per 4 cycles.
- READY in cycle N, AHB_START high in cycle N+2, payload stable from cycle N+1 through N+3.
- FIFO_FULL is sampled only in IDLE. It may rise after acceptance; the command in flight completes.
- Read return: RVALID is 3 cycles after the return FSM leaves R_IDLE; one delivery per 4 cycles.
- Read data is delivered in issue order, regardless of owner.
- Tag pointers wrap modulo C_TAG_DEPTH. Full = count == C_TAG_DEPTH; empty = count == 0.

## Configuration
- AHB_ARB_FIXED_PRIO_EN defined: R0 always wins when both requesters are eligible, and the last-winner flop is removed.
- Not defined: round-robin as above.

## Test plan
- Reset, then R0 write (addr 0x100, data 0xA5A5A5A5, burst 000) -> R0_READY in cycle N. AHB_START is high only in N+2, with AR_SEND = 0x100, DATA_SEND = 0xA5A5A5A5, TRAN_TYPE = 1, TRAN_STATUS = 2'b10.
- R0 and R1 both hold VALID for 4 commands -> grants alternate R0, R1, R0, R1. With AHB_ARB_FIXED_PRIO_EN, all four grants go to R0 while it stays valid.
- R0 read of 0x200, then R1 read of 0x300. The model returns 0x11111111 then 0x22222222 -> R0_RVALID with 0x11111111, then R1_RVALID with 0x22222222. OUTSTANDING goes 0 -> 1 -> 2 -> 1 -> 0.
- Issue 8 unreturned reads from R0 (OUTSTANDING = 8) -> R0 read stalls with R0_READY = 0. An R1 write is still accepted.
- RECV_FIFO_EMPTY = 0 with no reads issued -> RECV_RD stays 0 and ARB_ERR = 1 until M_nREST is asserted.
- Assert M_nREST low while the issue FSM is in SETUP -> AHB_START never pulses, OUTSTANDING = 0, and all outputs return to reset values.
